// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer for one- and two-word instructions
module fetch_unit #(
    parameter int IMM_BIT = 15
) (
    input  logic        clk,
    input  logic        notClr,
    input  logic [15:0] pc_in,
    output logic        pc_inc,
    input  logic        fetch_en,
    input  logic        flush,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] ir,
    output logic [15:0] imm,
    output logic        instr_valid
);

    typedef enum logic [2:0] {
        IDLE,
        REQ1,
        INC1,
        REQ2,
        INC2,
        VALID
    } state_t;

    state_t state;

    always_ff @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_addr    <= 16'h0000;
            pc_inc      <= 1'b0;
            ir          <= 16'h0000;
            imm         <= 16'h0000;
            instr_valid <= 1'b0;
        end else begin
            // pc_inc is a single-cycle pulse; only an accepted word raises it
            pc_inc <= 1'b0;
            if (flush) begin
                state       <= IDLE;
                mem_req     <= 1'b0;
                instr_valid <= 1'b0;
            end else begin
                case (state)
                    IDLE, VALID: begin
                        if (fetch_en) begin
                            state       <= REQ1;
                            mem_addr    <= pc_in;
                            mem_req     <= 1'b1;
                            instr_valid <= 1'b0;
                        end
                    end
                    REQ1: begin
                        if (mem_ack) begin
                            ir      <= mem_data;
                            mem_req <= 1'b0;
                            pc_inc  <= 1'b1;
                            state   <= INC1;
                        end
                    end
                    INC1: begin
                        if (ir[IMM_BIT]) begin
                            mem_addr <= mem_addr + 16'd1;
                            mem_req  <= 1'b1;
                            state    <= REQ2;
                        end else begin
                            imm         <= 16'h0000;
                            instr_valid <= 1'b1;
                            state       <= VALID;
                        end
                    end
                    REQ2: begin
                        if (mem_ack) begin
                            imm     <= mem_data;
                            mem_req <= 1'b0;
                            pc_inc  <= 1'b1;
                            state   <= INC2;
                        end
                    end
                    INC2: begin
                        instr_valid <= 1'b1;
                        state       <= VALID;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed check of fetch_unit against a word-counting model
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        notClr = 1'b1;
    logic [15:0] pc_in = 16'h0000;
    logic        pc_inc;
    logic        fetch_en = 1'b0;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_data = 16'h0000;
    logic [15:0] ir;
    logic [15:0] imm;
    logic        instr_valid;

    int vectors = 0;
    int miscompares = 0;
    int pulses = 0;

    fetch_unit #(.IMM_BIT(15)) dut (
        .clk(clk), .notClr(notClr), .pc_in(pc_in), .pc_inc(pc_inc),
        .fetch_en(fetch_en), .flush(flush), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .ir(ir), .imm(imm), .instr_valid(instr_valid)
    );

    always #5 clk = ~clk;

    // Model: a fetch is "busy" until all its words are in; words_got counts
    // accepted words, and a non-requesting busy cycle is the increment gap.
    bit          busy = 0;
    int          words_got = 0;
    bit          m_req = 0, m_inc = 0, m_valid = 0;
    logic [15:0] m_addr = 0, m_ir = 0, m_imm = 0;

    always @(posedge clk or negedge notClr) begin
        if (!notClr) begin
            busy = 0; words_got = 0; m_req = 0; m_inc = 0; m_valid = 0;
            m_addr = 0; m_ir = 0; m_imm = 0;
        end else begin
            m_inc = 0;
            if (flush) begin
                busy = 0; m_req = 0; m_valid = 0;
            end else if (!busy) begin
                if (fetch_en) begin
                    busy = 1; words_got = 0; m_req = 1; m_addr = pc_in; m_valid = 0;
                end
            end else if (m_req) begin
                if (mem_ack) begin
                    if (words_got == 0) m_ir = mem_data;
                    else m_imm = mem_data;
                    words_got++;
                    m_req = 0;
                    m_inc = 1;
                end
            end else if (words_got == 1 && m_ir[15]) begin
                m_addr = m_addr + 16'd1;
                m_req = 1;
            end else begin
                if (words_got == 1) m_imm = 16'h0000;
                m_valid = 1;
                busy = 0;
            end
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic compare_model();
        chk("mem_req", {15'd0, mem_req}, {15'd0, m_req});
        chk("mem_addr", mem_addr, m_addr);
        chk("pc_inc", {15'd0, pc_inc}, {15'd0, m_inc});
        chk("ir", ir, m_ir);
        chk("imm", imm, m_imm);
        chk("instr_valid", {15'd0, instr_valid}, {15'd0, m_valid});
    endtask

    // Advance one clock and check the registered outputs at the following negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (pc_inc === 1'b1) pulses++;
        compare_model();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_req"}, {15'd0, mem_req}, 16'h0);
        chk({tag, "_addr"}, mem_addr, 16'h0);
        chk({tag, "_inc"}, {15'd0, pc_inc}, 16'h0);
        chk({tag, "_ir"}, ir, 16'h0);
        chk({tag, "_imm"}, imm, 16'h0);
        chk({tag, "_valid"}, {15'd0, instr_valid}, 16'h0);
    endtask

    int p0;

    initial begin
        #1 notClr = 1'b0;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        notClr = 1'b1;
        compare_model();

        // One-word instruction, zero wait: valid on the third cycle.
        p0 = pulses;
        pc_in = 16'h0010; fetch_en = 1; mem_ack = 1; mem_data = 16'h1234;
        tick();
        chk("s1_addr", mem_addr, 16'h0010);
        chk("s1_req", {15'd0, mem_req}, 16'h1);
        fetch_en = 0;
        tick();
        chk("s1_ir", ir, 16'h1234);
        chk("s1_valid_early", {15'd0, instr_valid}, 16'h0);
        tick();
        chk("s1_valid", {15'd0, instr_valid}, 16'h1);
        chk("s1_imm", imm, 16'h0000);
        tick();
        chk("s1_pulses", 16'(pulses - p0), 16'd1);

        // Two-word instruction: valid on the fifth cycle.
        p0 = pulses;
        pc_in = 16'h0020; fetch_en = 1; mem_data = 16'h8001;
        tick();
        chk("s2_addr0", mem_addr, 16'h0020);
        fetch_en = 0;
        tick();
        chk("s2_ir", ir, 16'h8001);
        mem_data = 16'hBEEF;
        tick();
        chk("s2_addr1", mem_addr, 16'h0021);
        tick();
        chk("s2_valid_early", {15'd0, instr_valid}, 16'h0);
        tick();
        chk("s2_valid", {15'd0, instr_valid}, 16'h1);
        chk("s2_imm", imm, 16'hBEEF);
        chk("s2_pulses", 16'(pulses - p0), 16'd2);

        // Address wrap on the immediate word.
        pc_in = 16'hFFFF; fetch_en = 1; mem_data = 16'h8000;
        tick();
        fetch_en = 0;
        tick();
        tick();
        chk("s3_wrap", mem_addr, 16'h0000);
        chk("s3_req", {15'd0, mem_req}, 16'h1);
        mem_data = 16'h5555;
        tick(); tick();
        chk("s3_imm", imm, 16'h5555);

        // Wait states in REQ1.
        p0 = pulses;
        pc_in = 16'h0030; fetch_en = 1; mem_ack = 0; mem_data = 16'h0042;
        tick();
        fetch_en = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("s4_req", {15'd0, mem_req}, 16'h1);
            chk("s4_addr", mem_addr, 16'h0030);
            chk("s4_noinc", 16'(pulses - p0), 16'd0);
        end
        mem_ack = 1;
        tick();
        chk("s4_inc", {15'd0, pc_inc}, 16'h1);
        tick();
        chk("s4_ir", ir, 16'h0042);

        // Flush with mem_ack in REQ2.
        pc_in = 16'h0040; fetch_en = 1; mem_data = 16'h8002;
        tick();
        fetch_en = 0;
        tick(); tick();
        p0 = pulses;
        flush = 1; mem_data = 16'hDEAD;
        tick();
        chk("s5_imm", imm, 16'h0000);
        chk("s5_valid", {15'd0, instr_valid}, 16'h0);
        chk("s5_req", {15'd0, mem_req}, 16'h0);
        flush = 0;
        tick();
        chk("s5_idle", {15'd0, mem_req}, 16'h0);
        chk("s5_noinc", 16'(pulses - p0), 16'd0);

        // Asynchronous reset in the middle of REQ1, then a clean fetch.
        p0 = pulses;
        pc_in = 16'h0050; fetch_en = 1; mem_ack = 0;
        tick();
        fetch_en = 0;
        #2 notClr = 0;
        #1 check_all_zero("s6");
        #1 notClr = 1;
        tick();
        chk("s6_noinc", 16'(pulses - p0), 16'd0);
        pc_in = 16'h0060; fetch_en = 1; mem_ack = 1; mem_data = 16'h1111;
        tick();
        chk("s6_addr", mem_addr, 16'h0060);
        fetch_en = 0;
        tick(); tick();
        chk("s6_ir", ir, 16'h1111);
        chk("s6_valid", {15'd0, instr_valid}, 16'h1);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            fetch_en = ($urandom_range(0, 9) < 3);
            flush    = ($urandom_range(0, 19) == 0);
            mem_ack  = $urandom_range(0, 1);
            mem_data = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mem_data[15] = 1'b1;
            pc_in    = 16'($urandom);
            if ($urandom_range(0, 15) == 0) pc_in = 16'hFFFF;
            if ($urandom_range(0, 199) == 0) begin
                #2 notClr = 0;
                #1 check_all_zero("rnd_rst");
                #1 notClr = 1;
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
